// File: rtl/led_piano_pkg.sv
// Shared definitions for the LED piano sequencer: state encoding, register map, note decode.
package led_piano_pkg;

    typedef enum logic [1:0] {StIdle, StLoad, StPlay, StGap} state_e;

    // Register addresses
    localparam logic [1:0] ADDR_CTRL  = 2'd0;
    localparam logic [1:0] ADDR_NOTE  = 2'd1;
    localparam logic [1:0] ADDR_CLEAR = 2'd2;
    localparam logic [1:0] ADDR_LEDS  = 2'd3;

    // CTRL write bits
    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned CTRL_LOOP   = 1;
    localparam int unsigned CTRL_STOP   = 2;
    localparam int unsigned CTRL_IRQ_EN = 3;

    // CTRL read bits
    localparam int unsigned RD_BUSY    = 0;
    localparam int unsigned RD_DONE    = 1;
    localparam int unsigned RD_OVF     = 2;
    localparam int unsigned RD_IRQ_EN  = 3;
    localparam int unsigned RD_IDX_LSB = 8;

    localparam logic [2:0] NOTE_REST = 3'd7;

    // One-hot LED pattern for a note code; REST lights nothing.
    function automatic logic [6:0] note_leds(input logic [2:0] code);
        return (code == NOTE_REST) ? 7'd0 : (7'd1 << code);
    endfunction

endpackage

// File: rtl/led_piano_tick_gen.sv
// Tick prescaler: one-cycle tick every TICK_DIV enabled cycles, restartable via clear.
module led_piano_tick_gen #(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick,
    output logic pre_tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(TICK_DIV - 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise wrap at TICK_DIV-1 while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Not gated by clear: the caller derives clear from a state change that tick itself causes.
    assign tick     = enable && (cnt_q == CNT_LAST);
    // One cycle early, so a following one-cycle LOAD completes the tick.
    assign pre_tick = enable && (cnt_q == CNT_PRE);

endmodule

// File: rtl/led_piano_sequencer.sv
// Avalon-MM slave that plays a CPU-loaded melody on the 7-LED piano display.
module led_piano_sequencer
    import led_piano_pkg::*;
#(
    parameter int unsigned NOTE_DEPTH = 16,
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned DUR_W      = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [6:0]  out_port,
    output logic        irq
);

    localparam int unsigned AW = $clog2(NOTE_DEPTH);
    localparam int unsigned CW = AW + 1;

    state_e           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [6:0]       out_q, out_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic             loop_q, loop_d;
    logic             irq_en_q, irq_en_d;
    logic             buf_we;

    logic [2:0]       note_code [NOTE_DEPTH];
    logic [DUR_W-1:0] note_dur  [NOTE_DEPTH];

    logic wr, busy, last_note, tick, pre_tick, tick_clear, tick_en;

    assign wr         = chipselect & ~write_n;
    assign busy       = (state_q != StIdle);
    assign last_note  = ({1'b0, idx_q} == (count_q - CW'(1)));
    // Any state change restarts the prescaler so each phase starts on a fresh tick.
    assign tick_clear = (state_d != state_q) || (state_q == StIdle);
    assign tick_en    = (state_q == StPlay) || (state_q == StGap);

    led_piano_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .reset   (reset),
        .clear   (tick_clear),
        .enable  (tick_en),
        .tick    (tick),
        .pre_tick(pre_tick)
    );

    // Next-state: playback FSM first, then bus writes (STOP overrides playback).
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        count_d  = count_q;
        dur_d    = dur_q;
        out_d    = out_q;
        done_d   = done_q;
        ovf_d    = ovf_q;
        loop_d   = loop_q;
        irq_en_d = irq_en_q;
        buf_we   = 1'b0;

        unique case (state_q)
            StIdle: ;
            StLoad: begin
                dur_d   = (note_dur[idx_q] == '0) ? DUR_W'(1) : note_dur[idx_q];
                out_d   = note_leds(note_code[idx_q]);
                state_d = StPlay;
            end
            StPlay: begin
                if (tick) begin
                    if (dur_q <= DUR_W'(1)) begin
                        state_d = StGap;
                        out_d   = '0;
                    end else begin
                        dur_d = dur_q - DUR_W'(1);
                    end
                end
            end
            StGap: begin
                if (last_note && !loop_q) begin
                    if (tick) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end else if (pre_tick) begin
                    // Leave early: the LOAD cycle is the last blank cycle of the gap.
                    state_d = StLoad;
                    idx_d   = last_note ? '0 : idx_q + AW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (wr) begin
            unique case (address)
                ADDR_CTRL: begin
                    irq_en_d = writedata[CTRL_IRQ_EN];
                    if (writedata[CTRL_STOP]) begin
                        state_d = StIdle;
                        out_d   = '0;
                        idx_d   = '0;
                    end else if (writedata[CTRL_START] && !busy) begin
                        if (count_q != '0) begin
                            state_d = StLoad;
                            idx_d   = '0;
                            loop_d  = writedata[CTRL_LOOP];
                            done_d  = 1'b0;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                ADDR_NOTE: begin
                    if (!busy) begin
                        if (count_q == CW'(NOTE_DEPTH)) begin
                            ovf_d = 1'b1;
                        end else begin
                            buf_we  = 1'b1;
                            count_d = count_q + CW'(1);
                        end
                    end
                end
                ADDR_CLEAR: begin
                    if (!busy) begin
                        done_d  = 1'b0;
                        ovf_d   = 1'b0;
                        count_d = '0;
                    end
                end
                ADDR_LEDS: ;
                default: ;
            endcase
        end
    end

    // Control and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            count_q  <= '0;
            dur_q    <= '0;
            out_q    <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            loop_q   <= 1'b0;
            irq_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            count_q  <= count_d;
            dur_q    <= dur_d;
            out_q    <= out_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            loop_q   <= loop_d;
            irq_en_q <= irq_en_d;
        end
    end

    // Melody buffer; append slot is the current count, contents survive reset.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            note_code[count_q[AW-1:0]] <= writedata[2:0];
            note_dur[count_q[AW-1:0]]  <= writedata[8 +: DUR_W];
        end
    end

    // Zero-latency read mux.
    always_comb begin
        readdata = '0;
        unique case (address)
            ADDR_CTRL: begin
                readdata[RD_BUSY]         = busy;
                readdata[RD_DONE]         = done_q;
                readdata[RD_OVF]          = ovf_q;
                readdata[RD_IRQ_EN]       = irq_en_q;
                readdata[RD_IDX_LSB +: AW] = idx_q;
            end
            ADDR_NOTE:  readdata[CW-1:0] = count_q;
            ADDR_CLEAR: ;
            ADDR_LEDS:  readdata[6:0] = out_q;
            default: ;
        endcase
    end

    assign out_port = out_q;
    assign irq      = done_q & irq_en_q;

endmodule

// File: tb/tb_led_piano_sequencer.sv
// Directed bench for led_piano_sequencer with a per-cycle out_port scoreboard.
module tb_led_piano_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [6:0]  out_port;
    logic        irq;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q[$];
    logic [31:0] rd_val;

    always #5 clk = ~clk;

    led_piano_sequencer #(
        .NOTE_DEPTH(16),
        .TICK_DIV  (4),
        .DUR_W     (10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port),
        .irq       (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the write lands on the next posedge, returns at the following negedge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic check_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        rd_val     = readdata;
        chipselect = 1'b0;
        check(tag, rd_val, exp);
    endtask

    task automatic push_n(input logic [31:0] v, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(v);
    endtask

    // Pop one expected LED value per cycle; optionally issue bus writes at given cycle indices.
    task automatic run_sb(input string tag,
                          input int a_at, input logic [1:0] a_addr, input logic [31:0] a_data,
                          input int b_at, input logic [1:0] b_addr, input logic [31:0] b_data);
        int i;
        logic [31:0] e;
        i = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("%s_led[%0d]", tag, i), 32'(out_port), e);
            check($sformatf("%s_irq[%0d]", tag, i), 32'(irq), 32'd0);
            if (i == a_at) bus_write(a_addr, a_data);
            else if (i == b_at) bus_write(b_addr, b_data);
            else @(negedge clk);
            i++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // 1. Reset state
        check_reg("rst_ctrl", 2'd0, 32'h0);
        check_reg("rst_count", 2'd1, 32'h0);
        check_reg("rst_leds", 2'd3, 32'h0);
        check("rst_out_port", 32'(out_port), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);

        // 2. Two-note melody, single pass
        bus_write(2'd1, 32'h0000_0200);
        bus_write(2'd1, 32'h0000_0106);
        check_reg("t2_count", 2'd1, 32'd2);
        bus_write(2'd0, 32'h1);
        push_n(32'h00, 1);
        push_n(32'h01, 8);
        push_n(32'h00, 4);
        push_n(32'h40, 4);
        push_n(32'h00, 4);
        run_sb("t2", -1, 2'd0, 32'h0, -1, 2'd0, 32'h0);
        check_reg("t2_ctrl_done", 2'd0, 32'h102);
        check("t2_irq", 32'(irq), 32'h0);

        // 3. Looping playback with irq_en, stopped in the second pass
        bus_write(2'd2, 32'h0);
        bus_write(2'd1, 32'h0000_0200);
        bus_write(2'd1, 32'h0000_0106);
        bus_write(2'd0, 32'hB);
        push_n(32'h00, 1);
        push_n(32'h01, 8);
        push_n(32'h00, 4);
        push_n(32'h40, 4);
        push_n(32'h00, 4);
        push_n(32'h01, 4);
        run_sb("t3", 24, 2'd0, 32'hC, -1, 2'd0, 32'h0);
        check("t3_stop_out", 32'(out_port), 32'h0);
        check("t3_stop_irq", 32'(irq), 32'h0);
        check_reg("t3_ctrl", 2'd0, 32'h8);

        // 4. Overflow on the 17th note, then CLEAR
        bus_write(2'd2, 32'h0);
        for (int n = 0; n < 17; n++) bus_write(2'd1, 32'(n));
        check_reg("t4_count", 2'd1, 32'd16);
        check_reg("t4_ovf", 2'd0, 32'hC);
        bus_write(2'd2, 32'h0);
        check_reg("t4_clr_count", 2'd1, 32'd0);
        check_reg("t4_clr_ctrl", 2'd0, 32'h8);

        // 5. START with empty buffer
        bus_write(2'd0, 32'h9);
        check("t5_irq", 32'(irq), 32'h1);
        check_reg("t5_ctrl", 2'd0, 32'hA);
        bus_write(2'd2, 32'h0);
        check("t5_irq_clr", 32'(irq), 32'h0);

        // 6. REST with dur 0, writes while busy are ignored
        bus_write(2'd1, 32'h0000_0007);
        bus_write(2'd1, 32'h0000_0103);
        bus_write(2'd0, 32'h9);
        push_n(32'h00, 9);
        push_n(32'h08, 4);
        push_n(32'h00, 4);
        run_sb("t6", 2, 2'd1, 32'h0000_0105, 5, 2'd0, 32'h9);
        check("t6_irq", 32'(irq), 32'h1);
        check_reg("t6_count", 2'd1, 32'd2);
        check_reg("t6_ctrl", 2'd0, 32'h10A);

        // Reset in the middle of playback
        bus_write(2'd0, 32'h1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_out", 32'(out_port), 32'h0);
        check("mid_rst_irq", 32'(irq), 32'h0);
        check_reg("mid_rst_ctrl", 2'd0, 32'h0);
        check_reg("mid_rst_count", 2'd1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
